cnt_ndigit_prescaled: RTL and testbench

Parametrised N-digit, base-B up/down counter with a built-in prescaler, synchronous parallel load and terminal-count reporting. It is the general successor to the fixed 5-digit counter: digit count, radix, clock frequency and step rate are all parameters, and it adds a terminal-count pulse and optional saturation. It sits between the debounced key/switch inputs and the per-digit 7-segment decoders. One 4-bit nibble per digit.

---
 rtl/cnt_ndigit_prescaled.sv | 117 +++++++++++
 tb/tb_cnt_ndigit_prescaled.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_ndigit_prescaled.sv
// ============================================================================
// Module      : cnt_ndigit_prescaled
// Description : N-digit base-B up/down counter with prescaler, parallel load
//               with per-digit clamping and terminal-count pulse.
//               Optional saturation at the terminal state: CNT_NDIGIT_SATURATE_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_ndigit_prescaled #(
    parameter int DIGITS        = 5,
    parameter int BASE          = 10,
    parameter int FREQ          = 50000000,
    parameter int STEPS_PER_SEC = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  nLoad,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  step,
    output logic                  tc
);

    localparam int              DIV        = FREQ / STEPS_PER_SEC;
    localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   C_DIV_LAST = PW'(DIV - 1);
    localparam logic [3:0]      C_MAX      = 4'(BASE - 1);
    localparam logic [4:0]      C_BASE     = 5'(BASE);

`ifdef CNT_NDIGIT_SATURATE_EN
    localparam bit              C_SATURATE = 1'b1;
`else
    localparam bit              C_SATURATE = 1'b0;
`endif

    logic [PW-1:0]          r_presc;
    logic [4*DIGITS-1:0]    r_count;
    logic                   r_step;
    logic                   r_tc;

    logic [DIGITS:0]        w_carry_up;
    logic [DIGITS:0]        w_borrow_dn;
    logic [4*DIGITS-1:0]    w_count_up;
    logic [4*DIGITS-1:0]    w_count_dn;
    logic [4*DIGITS-1:0]    w_load_clamped;
    logic [4*DIGITS-1:0]    w_count_next;
    logic [PW-1:0]          w_presc_next;
    logic                   w_step_now;
    logic                   w_terminal;

    // Ripple enables: a digit moves only when all lower digits are at the
    // rollover value for the current direction.
    assign w_carry_up[0]  = 1'b1;
    assign w_borrow_dn[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] w_dig;
            logic [3:0] w_ld;
            assign w_dig = r_count[4*i +: 4];
            assign w_ld  = load_val[4*i +: 4];

            assign w_carry_up[i+1]  = w_carry_up[i]  & (w_dig == C_MAX);
            assign w_borrow_dn[i+1] = w_borrow_dn[i] & (w_dig == 4'd0);

            assign w_count_up[4*i +: 4] = !w_carry_up[i]     ? w_dig :
                                          (w_dig == C_MAX)   ? 4'd0  :
                                                               w_dig + 4'd1;
            assign w_count_dn[4*i +: 4] = !w_borrow_dn[i]    ? w_dig :
                                          (w_dig == 4'd0)    ? C_MAX :
                                                               w_dig - 4'd1;
            // Widened compare so BASE = 16 never clamps.
            assign w_load_clamped[4*i +: 4] = ({1'b0, w_ld} >= C_BASE) ? C_MAX : w_ld;
        end
    endgenerate

    assign w_step_now   = enable & (r_presc == C_DIV_LAST);
    assign w_presc_next = (r_presc == C_DIV_LAST) ? '0 : r_presc + PW'(1);
    assign w_terminal   = up ? w_carry_up[DIGITS] : w_borrow_dn[DIGITS];
    assign w_count_next = (C_SATURATE && w_terminal) ? r_count :
                          (up ? w_count_up : w_count_dn);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_count <= '0;
            r_step  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (!nLoad) begin
            r_presc <= '0;
            r_count <= w_load_clamped;
            r_step  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_tc   <= 1'b0;
            if (enable) begin
                r_presc <= w_presc_next;
            end
            if (w_step_now) begin
                r_step  <= 1'b1;
                r_tc    <= w_terminal;
                r_count <= w_count_next;
            end
        end
    end

    assign count = r_count;
    assign step  = r_step;
    assign tc    = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_cnt_ndigit_prescaled.sv
// ============================================================================
// Module      : tb_cnt_ndigit_prescaled
// Description : Bench for cnt_ndigit_prescaled: a 2-digit decimal DIV=10
//               instance and a 2-digit hex DIV=1 instance, checked each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_ndigit_prescaled;

`ifdef CNT_NDIGIT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       a_nload;
    logic       up;
    logic [7:0] a_lv;
    logic [7:0] a_count;
    logic       a_step;
    logic       a_tc;
    logic       b_nload;
    logic [7:0] b_lv;
    logic [7:0] b_count;
    logic       b_step;
    logic       b_tc;

    always #5 clk = ~clk;

    cnt_ndigit_prescaled #(
        .DIGITS(2), .BASE(10), .FREQ(10), .STEPS_PER_SEC(1)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .enable(enable), .nLoad(a_nload),
        .up(up), .load_val(a_lv), .count(a_count), .step(a_step), .tc(a_tc)
    );

    cnt_ndigit_prescaled #(
        .DIGITS(2), .BASE(16), .FREQ(5), .STEPS_PER_SEC(5)
    ) dut16 (
        .CLOCK_50(clk), .reset(reset), .enable(enable), .nLoad(b_nload),
        .up(up), .load_val(b_lv), .count(b_count), .step(b_step), .tc(b_tc)
    );

    typedef struct {
        logic [7:0] a_count;
        logic       a_step;
        logic       a_tc;
        logic [7:0] b_count;
        logic       b_step;
        logic       b_tc;
    } exp_t;

    typedef struct {
        logic       nl;
        logic       en;
        logic       dir;
        logic [7:0] lv;
        int         cyc;
        logic [7:0] exp_count;
        logic       exp_tc;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: counts kept as plain integers
    int m_a_val, m_a_presc, m_b_val;

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        logic [3:0] h, l;
        h = 4'(v / 10);
        l = 4'(v % 10);
        return {h, l};
    endfunction

    function automatic int clamp_bcd(logic [7:0] lv);
        int h, l;
        h = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        l = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return h * 10 + l;
    endfunction

    task automatic tick();
        exp_t e;
        bit   term;
        e = '{default: '0};
        // decimal, DIV = 10
        if (!a_nload) begin
            m_a_val   = clamp_bcd(a_lv);
            m_a_presc = 0;
        end else if (enable) begin
            if (m_a_presc == 9) begin
                m_a_presc = 0;
                term      = up ? (m_a_val == 99) : (m_a_val == 0);
                e.a_step  = 1'b1;
                e.a_tc    = term;
                if (!(SAT && term))
                    m_a_val = up ? (m_a_val + 1) % 100 : (m_a_val + 99) % 100;
            end else begin
                m_a_presc++;
            end
        end
        e.a_count = to_bcd(m_a_val);
        // hex, DIV = 1
        if (!b_nload) begin
            m_b_val = int'(b_lv);
        end else if (enable) begin
            term     = up ? (m_b_val == 255) : (m_b_val == 0);
            e.b_step = 1'b1;
            e.b_tc   = term;
            if (!(SAT && term))
                m_b_val = up ? (m_b_val + 1) % 256 : (m_b_val + 255) % 256;
        end
        e.b_count = 8'(m_b_val);
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            chk("a_count", a_count, e.a_count);
            chk("a_step",  {7'd0, a_step}, {7'd0, e.a_step});
            chk("a_tc",    {7'd0, a_tc},   {7'd0, e.a_tc});
            chk("b_count", b_count, e.b_count);
            chk("b_step",  {7'd0, b_step}, {7'd0, e.b_step});
            chk("b_tc",    {7'd0, b_tc},   {7'd0, e.b_tc});
        end
    endtask

    task automatic model_reset();
        m_a_val   = 0;
        m_a_presc = 0;
        m_b_val   = 0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        a_nload = 1'b1;
        up      = 1'b1;
        a_lv    = 8'h00;
        b_nload = 1'b1;
        b_lv    = 8'h00;
        model_reset();

        // nl en up lv cycles exp_count exp_tc
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00,  9, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00,  1, 8'h01, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 8'hA7,  1, 8'h97, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 10, 8'h98, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h99,  1, 8'h99, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00,  9, 8'h99, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00,  1, SAT ? 8'h99 : 8'h00, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h10,  1, 8'h10, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 10, 8'h09, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 10, 8'h08, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'h00,  1, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 10, SAT ? 8'h00 : 8'h99, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00, 10, SAT ? 8'h01 : 8'h00, SAT ? 1'b0 : 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h20,  1, 8'h20, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00,  4, 8'h20, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'h00,  7, 8'h20, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00,  5, 8'h20, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00,  1, 8'h21, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h55,  1, 8'h55, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h42,  1, 8'h42, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'h00,  3, 8'h42, 1'b0});

        #1;
        chk("reset_count", a_count, 8'h00);
        chk("reset_step",  {7'd0, a_step}, 8'h00);
        chk("reset_tc",    {7'd0, a_tc},   8'h00);
        chk("reset_count16", b_count, 8'h00);
        #1;
        reset = 1'b0;

        foreach (tbl[k]) begin
            a_nload = tbl[k].nl;
            enable  = tbl[k].en;
            up      = tbl[k].dir;
            a_lv    = tbl[k].lv;
            for (int c = 0; c < tbl[k].cyc; c++) tick();
            chk($sformatf("vec%0d_count", k), a_count, tbl[k].exp_count);
            chk($sformatf("vec%0d_tc", k), {7'd0, a_tc}, {7'd0, tbl[k].exp_tc});
        end

        // Asynchronous reset between edges with count = 0x42
        a_nload = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_count", a_count, 8'h00);
        chk("async_rst_step",  {7'd0, a_step}, 8'h00);
        chk("async_rst_count16", b_count, 8'h00);
        #1;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 9; c++) tick();
        chk("restart_hold", a_count, 8'h00);
        tick();
        chk("restart_step", a_count, 8'h01);

        // Hex instance, DIV = 1: FD -> FE -> FF -> wrap
        up      = 1'b1;
        enable  = 1'b1;
        b_nload = 1'b0;
        b_lv    = 8'hFD;
        tick();
        chk("hex_load", b_count, 8'hFD);
        b_nload = 1'b1;
        tick();
        chk("hex_fe", b_count, 8'hFE);
        tick();
        chk("hex_ff", b_count, 8'hFF);
        tick();
        chk("hex_wrap", b_count, SAT ? 8'hFF : 8'h00);
        chk("hex_wrap_tc", {7'd0, b_tc}, 8'h01);
        tick();
        chk("hex_tc_one_cycle", {7'd0, b_tc}, SAT ? 8'h01 : 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
